// File: rtl/t05_hdecode.sv
`default_nettype none
// ============================================================================
// Module   : t05_hdecode
// Purpose  : Huffman tree walker for the decompression path. Fetches tree
//            nodes from SRAM, consumes the compressed stream one bit at a
//            time and emits one 8-bit character for each leaf it reaches.
// Ports    :
//   clk, rst_n            clock; reset is asynchronous and active-high
//   start                 begin a decode (accepted in IDLE, DONE or ERR)
//   root_idx, total_chars root node index and character count, latched on start
//   bit_in/valid/ready    compressed bit stream (0 = left, 1 = right)
//   rd_req, rd_addr       one-cycle SRAM read request and node index
//   rd_data, read_complete  node {idx, left, right, sum} and its strobe
//   char_out/valid/ready  decoded character stream
//   done, err             decode finished / malformed tree, held until start
// Revision : 1.0  initial release
// ============================================================================
module t05_hdecode #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [6:0]       root_idx,
    input  logic [CNT_W-1:0] total_chars,
    input  logic             bit_in,
    input  logic             bit_valid,
    output logic             bit_ready,
    output logic             rd_req,
    output logic [6:0]       rd_addr,
    input  logic [70:0]      rd_data,
    input  logic             read_complete,
    output logic [7:0]       char_out,
    output logic             char_valid,
    input  logic             char_ready,
    output logic             done,
    output logic             err
);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_ROOT_RD   = 4'd1,
        S_ROOT_WAIT = 4'd2,
        S_BIT       = 4'd3,
        S_NODE_RD   = 4'd4,
        S_NODE_WAIT = 4'd5,
        S_EMIT      = 4'd6,
        S_DONE      = 4'd7,
        S_ERR       = 4'd8
    } state_t;

    localparam logic [8:0] C_NULL_CHILD = 9'h180;

    state_t           state_q,      state_d;
    logic [6:0]       addr_q,       addr_d;       // index of the node being fetched
    logic [CNT_W-1:0] total_q,      total_d;
    logic [CNT_W-1:0] count_q,      count_d;
    logic [8:0]       root_l_q,     root_l_d;     // cached root children
    logic [8:0]       root_r_q,     root_r_d;
    logic [8:0]       cur_l_q,      cur_l_d;      // children of the current node
    logic [8:0]       cur_r_q,      cur_r_d;
    logic [7:0]       char_q,       char_d;
    logic             bit_ready_q,  bit_ready_d;
    logic             char_valid_q, char_valid_d;
    logic             rd_req_q,     rd_req_d;
    logic             done_q,       done_d;
    logic             err_q,        err_d;

    logic [8:0]       child;

    // The sum field is carried in the node format but plays no part in decoding.
    logic             unused_sum;
    assign unused_sum = ^rd_data[45:0];

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        total_d  = total_q;
        count_d  = count_q;
        root_l_d = root_l_q;
        root_r_d = root_r_q;
        cur_l_d  = cur_l_q;
        cur_r_d  = cur_r_q;
        char_d   = char_q;
        child    = bit_in ? cur_r_q : cur_l_q;

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    addr_d  = root_idx;
                    total_d = total_chars;
                    count_d = '0;
                    state_d = (total_chars == '0) ? S_DONE : S_ROOT_RD;
                end
            end
            S_ROOT_RD: state_d = S_ROOT_WAIT;
            S_ROOT_WAIT: begin
                if (read_complete) begin
                    if (rd_data[70:64] != addr_q) begin
                        state_d = S_ERR;
                    end else begin
                        root_l_d = rd_data[63:55];
                        root_r_d = rd_data[54:46];
                        cur_l_d  = rd_data[63:55];
                        cur_r_d  = rd_data[54:46];
                        state_d  = S_BIT;
                    end
                end
            end
            S_BIT: begin
                if (bit_valid) begin
                    if (child == C_NULL_CHILD) begin
                        state_d = S_ERR;
                    end else if (!child[8]) begin
                        char_d  = child[7:0];
                        state_d = S_EMIT;
                    end else begin
                        addr_d  = child[6:0];
                        state_d = S_NODE_RD;
                    end
                end
            end
            S_NODE_RD: state_d = S_NODE_WAIT;
            S_NODE_WAIT: begin
                if (read_complete) begin
                    if (rd_data[70:64] != addr_q) begin
                        state_d = S_ERR;
                    end else begin
                        cur_l_d = rd_data[63:55];
                        cur_r_d = rd_data[54:46];
                        state_d = S_BIT;
                    end
                end
            end
            S_EMIT: begin
                if (char_ready) begin
                    count_d = count_q + 1'b1;
                    if (count_d == total_q) begin
                        state_d = S_DONE;
                    end else begin
                        // Restart the walk from the cached root; no SRAM re-read.
                        cur_l_d = root_l_q;
                        cur_r_d = root_r_q;
                        state_d = S_BIT;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Handshake and status outputs are flopped decodes of the next state,
        // so they are glitch-free and bit_ready/char_valid stay exclusive.
        bit_ready_d  = (state_d == S_BIT);
        char_valid_d = (state_d == S_EMIT);
        rd_req_d     = (state_d == S_ROOT_RD) || (state_d == S_NODE_RD);
        done_d       = (state_d == S_DONE);
        err_d        = (state_d == S_ERR);
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            total_q      <= '0;
            count_q      <= '0;
            root_l_q     <= '0;
            root_r_q     <= '0;
            cur_l_q      <= '0;
            cur_r_q      <= '0;
            char_q       <= '0;
            bit_ready_q  <= 1'b0;
            char_valid_q <= 1'b0;
            rd_req_q     <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            total_q      <= total_d;
            count_q      <= count_d;
            root_l_q     <= root_l_d;
            root_r_q     <= root_r_d;
            cur_l_q      <= cur_l_d;
            cur_r_q      <= cur_r_d;
            char_q       <= char_d;
            bit_ready_q  <= bit_ready_d;
            char_valid_q <= char_valid_d;
            rd_req_q     <= rd_req_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign bit_ready  = bit_ready_q;
    assign char_valid = char_valid_q;
    assign rd_req     = rd_req_q;
    assign rd_addr    = addr_q;
    assign char_out   = char_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule
`default_nettype wire

// File: doc/t05_hdecode.md
# t05_hdecode

Huffman tree walker for the decompression path. It reads tree nodes back from SRAM in the 71-bit node format produced by the tree-construction stage, consumes a compressed bit stream one bit at a time, and emits one decoded 8-bit character per leaf reached. It sits between the SRAM read port and the character output sink, and is controlled by a start pulse from the controller.

## Interface
- `CNT_W`, default 32: width of the character-count input and the internal emitted-character counter.

- `clk` input, 1: single clock; all state changes on its rising edge.
- `rst_n` input, 1: reset; asynchronous and active-high (despite the name).
- `start` input, 1: one-cycle pulse. Accepted in IDLE, DONE or ERR; ignored in all other states.
- `root_idx` input, 7: SRAM index of the root node; latched on `start`.
- `total_chars` input, CNT_W: number of characters to decode; latched on `start`.
- `bit_in` input, 1: compressed bit. 0 selects the left child, 1 selects the right child.
- `bit_valid` input, 1: `bit_in` is valid.
- `bit_ready` output, 1: decoder accepts a bit this cycle.
- `rd_req` output, 1: one-cycle SRAM read request.
- `rd_addr` output, 7: node index to read.
- `rd_data` input, 71: node read from SRAM, laid out as {idx[70:64], left[63:55], right[54:46], sum[45:0]}.
- `read_complete` input, 1: one-cycle pulse; `rd_data` is valid in that cycle.
- `char_out` output, 8: decoded character.
- `char_valid` output, 1: `char_out` is valid.
- `char_ready` input, 1: sink accepts the character.
- `done` output, 1: decode finished; held until the next `start`.
- `err` output, 1: malformed tree detected; held until `start` or reset.

## Operation
Child encoding in the node fields:
- Bit 8 = 0: leaf, with the character in [7:0].
- Bit 8 = 1: sum node, with its SRAM index in [6:0].
- 9'h180 is NULL.

States:
- **IDLE**: on `start`, latch the inputs and clear the counter.
  - If `total_chars`==0, go to DONE.
  - Otherwise go to ROOT_RD.
- **ROOT_RD**: `rd_req`=1, `rd_addr`=root index, for exactly one cycle. Go to ROOT_WAIT.
- **ROOT_WAIT**: wait for `read_complete`, then capture `rd_data` into both the root register and the current-node register. Go to BIT.
- **BIT**: `bit_ready`=1. On `bit_valid`, select child = `bit_in` ? right : left.
  - NULL child: go to ERR.
  - Leaf: register `char_out`=child[7:0] and go to EMIT.
  - Sum node: go to NODE_RD with `rd_addr`=child[6:0].
- **NODE_RD**: `rd_req`=1 for one cycle. Go to NODE_WAIT.
- **NODE_WAIT**: on `read_complete`, current node = `rd_data`. Go to BIT.
- **EMIT**: `char_valid`=1 and `char_out` held stable. On `char_ready`, increment the counter.
  - If the new count equals `total_chars`, go to DONE.
  - Otherwise current node = cached root and go to BIT. The root is never re-read from SRAM.
- **DONE**: `done`=1.
- **ERR**: `err`=1.

Integrity check: in ROOT_WAIT and NODE_WAIT, `rd_data[70:64]` must equal the requested index. On mismatch, go to ERR.

Single-character tree (root = {idx, leaf, NULL}): bit 0 emits the leaf; bit 1 goes to ERR.

## Timing
Reset:
- All outputs are 0, state is IDLE, and all registers are cleared.
- Reset mid-decode abandons all progress; any SRAM response that arrives afterwards is ignored.

Handshakes:
- `bit_ready` and `char_valid` are registered state decodes and are never high in the same cycle.
- A bit is consumed only in a cycle where `bit_valid` && `bit_ready`.
- `char_valid`, once asserted, stays high with `char_out` stable until `char_ready`. Backpressure has no limit.

Latency, with a bit accepted at cycle t:
- Leaf: `char_valid` is high at t+1.
- Sum node: `rd_req` is high at t+1; `bit_ready` returns the cycle after `read_complete`.
- Leaf, with `char_ready` at cycle u: `bit_ready` is high at u+1, or `done` is high at u+1 on the last character.

Other timing rules:
- `read_complete` outside ROOT_WAIT or NODE_WAIT is ignored.
- `rd_req` is never reasserted while a read is outstanding.
- `start` during an active decode (any state other than IDLE, DONE or ERR) has no effect.
- Counter arithmetic is CNT_W-bit unsigned. `total_chars` = 2^CNT_W−1 must complete without wrap.

## Test plan
- **Nominal decode**
  - Setup: addr 1 = {1, 9'h042, 9'h043, 0}; addr 2 = {2, 9'h041, 9'h101, 0}; root 2, total 3; bits 0,1,0,1,1.
  - Required: chars 0x41, 0x42, 0x43; exactly 2 `rd_req` after the root read (addr 1 twice); `done`=1.
- **Backpressure**
  - Setup: same tree, `char_ready` held low for 10 cycles on each character.
  - Required: `char_out` stable, `bit_ready`=0 throughout each stall, output sequence unchanged.
- **Single-character tree**
  - Setup: root 0 = {0, 9'h05A, 9'h180}, total 4, bits 0,0,0,0.
  - Required: four 0x5A characters, then `done`.
  - Follow-up: restart with bit 1; required `err`=1 with no character emitted.
- **Index mismatch**
  - Setup: SRAM returns idx 5 for a request to addr 1.
  - Required: `err`=1 one cycle after `read_complete`; `bit_ready` stays 0.
- **Reset mid-decode**
  - Setup: assert `rst_n` during NODE_WAIT, then deliver `read_complete`.
  - Required: all outputs 0, no state change; a fresh `start` decodes correctly.
- **Zero length**
  - Setup: `start` with `total_chars`=0.
  - Required: `done`=1 at the next cycle; `rd_req` never asserted.
